// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin register-file writeback arbiter with WAW scoreboard; REGFILE_WB_BYPASS_EN builds the read bypass.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [5*NREQ-1:0]    req_rd,
  input  logic [XLEN*NREQ-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rf_write,
  output logic [4:0]           rf_rd,
  output logic [XLEN-1:0]      rf_data,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_rd,
  output logic                 issue_ready,
  output logic [31:0]          busy,
  input  logic [4:0]           byp_rs1_addr,
  input  logic [4:0]           byp_rs2_addr,
  output logic                 byp_rs1_hit,
  output logic                 byp_rs2_hit,
  output logic [XLEN-1:0]      byp_rs1_data,
  output logic [XLEN-1:0]      byp_rs2_data
);
  logic [1:0]      last_grant_q, last_grant_d, gnt_idx, idx;
  logic            hs;
  logic [4:0]      win_rd;
  logic [XLEN-1:0] win_data;
  logic            rf_write_q;
  logic [4:0]      rf_rd_q;
  logic [XLEN-1:0] rf_data_q;
  logic [31:0]     busy_q, busy_d;
  // Search starts just past the last winner and takes the first valid requester.
  always_comb begin
    hs = 1'b0;
    gnt_idx = '0;
    idx = '0;
    req_ready = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = 2'((int'(last_grant_q) + k) % NREQ);
      if (!hs && req_valid[idx]) begin
        hs = 1'b1;
        gnt_idx = idx;
        req_ready[idx] = 1'b1;
      end
    end
    win_rd = req_rd[5*int'(gnt_idx) +: 5];
    win_data = req_data[XLEN*int'(gnt_idx) +: XLEN];
    last_grant_d = hs ? gnt_idx : last_grant_q;
  end
  // Issue set is applied after the writeback clear so that it wins on a collision.
  always_comb begin
    busy_d = busy_q;
    if (hs) busy_d[win_rd] = 1'b0;
    if (issue_valid && issue_ready) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 2'(NREQ - 1);
      rf_write_q   <= 1'b0;
      rf_rd_q      <= '0;
      rf_data_q    <= '0;
      busy_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_write_q   <= hs && (win_rd != 5'd0);
      rf_rd_q      <= hs ? win_rd : rf_rd_q;
      rf_data_q    <= hs ? win_data : rf_data_q;
      busy_q       <= busy_d;
    end
  end
  assign rf_write    = rf_write_q;
  assign rf_rd       = rf_rd_q;
  assign rf_data     = rf_data_q;
  assign busy        = busy_q;
  assign issue_ready = (issue_rd == 5'd0) || !busy_q[issue_rd];
`ifdef REGFILE_WB_BYPASS_EN
  assign byp_rs1_hit  = rf_write_q && (rf_rd_q == byp_rs1_addr) && (byp_rs1_addr != 5'd0);
  assign byp_rs2_hit  = rf_write_q && (rf_rd_q == byp_rs2_addr) && (byp_rs2_addr != 5'd0);
  assign byp_rs1_data = byp_rs1_hit ? rf_data_q : '0;
  assign byp_rs2_data = byp_rs2_hit ? rf_data_q : '0;
`else
  assign byp_rs1_hit  = 1'b0;
  assign byp_rs2_hit  = 1'b0;
  assign byp_rs1_data = '0;
  assign byp_rs2_data = '0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed self-checking bench for regfile_wb_arbiter (NREQ=3, XLEN=64).
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  req_valid = '0;
  logic [4:0]  rd [3];
  logic [63:0] dat [3];
  logic [14:0] req_rd;
  logic [191:0] req_data;
  logic [2:0]  req_ready;
  logic        rf_write;
  logic [4:0]  rf_rd;
  logic [63:0] rf_data;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        issue_ready;
  logic [31:0] busy;
  logic [4:0]  byp_rs1_addr = '0, byp_rs2_addr = '0;
  logic        byp_rs1_hit, byp_rs2_hit;
  logic [63:0] byp_rs1_data, byp_rs2_data;
  int checks = 0;
  int errors = 0;
  assign req_rd   = {rd[2], rd[1], rd[0]};
  assign req_data = {dat[2], dat[1], dat[0]};
  always #5 clk = ~clk;
  regfile_wb_arbiter #(.NREQ(3), .XLEN(64)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
    .req_ready(req_ready), .rf_write(rf_write), .rf_rd(rf_rd), .rf_data(rf_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready), .busy(busy),
    .byp_rs1_addr(byp_rs1_addr), .byp_rs2_addr(byp_rs2_addr),
    .byp_rs1_hit(byp_rs1_hit), .byp_rs2_hit(byp_rs2_hit),
    .byp_rs1_data(byp_rs1_data), .byp_rs2_data(byp_rs2_data)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      rd[i] = '0;
      dat[i] = '0;
    end
    #1 rst = 1'b1;
    tick();
    tick();
    check("rst_write", 64'(rf_write), 64'd0);
    check("rst_rd", 64'(rf_rd), 64'd0);
    check("rst_data", rf_data, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    // all three requesters, grants rotate 0,1,2
    rd[0] = 5'd5; rd[1] = 5'd6; rd[2] = 5'd7;
    dat[0] = 64'd100; dat[1] = 64'd200; dat[2] = 64'd300;
    req_valid = 3'b111;
    #1 check("rr_g0", 64'(req_ready), 64'b001);
    tick();
    check("rr_w0", 64'(rf_write), 64'd1);
    check("rr_rd0", 64'(rf_rd), 64'd5);
    check("rr_d0", rf_data, 64'd100);
    check("rr_g1", 64'(req_ready), 64'b010);
    tick();
    check("rr_rd1", 64'(rf_rd), 64'd6);
    check("rr_g2", 64'(req_ready), 64'b100);
    tick();
    check("rr_w2", 64'(rf_write), 64'd1);
    check("rr_rd2", 64'(rf_rd), 64'd7);
    check("rr_d2", rf_data, 64'd300);
    req_valid = 3'b000;
    tick();
    check("idle_w", 64'(rf_write), 64'd0);
    check("idle_rd_hold", 64'(rf_rd), 64'd7);
    check("idle_ready", 64'(req_ready), 64'd0);
    // lone requester 2
    rd[2] = 5'd9; dat[2] = 64'hDEAD_BEEF;
    req_valid = 3'b100;
    #1 check("solo_g", 64'(req_ready), 64'b100);
    tick();
    req_valid = 3'b000;
    check("solo_w", 64'(rf_write), 64'd1);
    check("solo_rd", 64'(rf_rd), 64'd9);
    check("solo_d", rf_data, 64'hDEAD_BEEF);
    // x0 write completes but never writes the file
    rd[0] = 5'd0; dat[0] = 64'h11;
    req_valid = 3'b001;
    #1 check("x0_g", 64'(req_ready), 64'b001);
    tick();
    check("x0_w", 64'(rf_write), 64'd0);
    rd[1] = 5'd3; dat[1] = 64'h33;
    req_valid = 3'b011;
    #1 check("x0_next_g", 64'(req_ready), 64'b010);
    tick();
    req_valid = 3'b000;
    check("x0_next_w", 64'(rf_write), 64'd1);
    check("x0_next_rd", 64'(rf_rd), 64'd3);
    // scoreboard
    issue_valid = 1'b1; issue_rd = 5'd12;
    #1 check("iss_rdy0", 64'(issue_ready), 64'd1);
    tick();
    check("iss_busy", 64'(busy), 64'h1000);
    check("iss_rdy1", 64'(issue_ready), 64'd0);
    issue_valid = 1'b0;
    rd[2] = 5'd12; dat[2] = 64'hC0FFEE;
    req_valid = 3'b100;
    #1 check("clr_g", 64'(req_ready), 64'b100);
    tick();
    check("clr_busy", 64'(busy), 64'd0);
    check("clr_w", 64'(rf_write), 64'd1);
    check("clr_rd", 64'(rf_rd), 64'd12);
    byp_rs1_addr = 5'd12; byp_rs2_addr = 5'd0;
    #1;
`ifdef REGFILE_WB_BYPASS_EN
    check("byp1_hit", 64'(byp_rs1_hit), 64'd1);
    check("byp1_data", byp_rs1_data, 64'hC0FFEE);
`else
    check("byp1_hit", 64'(byp_rs1_hit), 64'd0);
    check("byp1_data", byp_rs1_data, 64'd0);
`endif
    check("byp2_hit", 64'(byp_rs2_hit), 64'd0);
    check("byp2_data", byp_rs2_data, 64'd0);
    issue_valid = 1'b1; issue_rd = 5'd12;
    #1 check("setwin_rdy", 64'(issue_ready), 64'd1);
    tick();
    check("setwin_busy", 64'(busy), 64'h1000);
    issue_rd = 5'd4;
    rd[0] = 5'd5; dat[0] = 64'h55;
    req_valid = 3'b001;
    tick();
    issue_valid = 1'b0;
    check("pre_rst_busy", 64'(busy), 64'h1010);
    check("pre_rst_w", 64'(rf_write), 64'd1);
    rd[0] = 5'd1; rd[1] = 5'd2; rd[2] = 5'd3;
    dat[0] = 64'hA1; dat[1] = 64'hA2; dat[2] = 64'hA3;
    req_valid = 3'b111;
    // asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1;
    check("arst_w", 64'(rf_write), 64'd0);
    check("arst_rd", 64'(rf_rd), 64'd0);
    check("arst_d", rf_data, 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("post_rst_g", 64'(req_ready), 64'b001);
    tick();
    check("post_rst_rd", 64'(rf_rd), 64'd1);
    check("post_rst_d", rf_data, 64'hA1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single write port of the integer register file between NREQ writeback producers (ALU, load unit, mul/div) using round-robin arbitration, and keeps a 32-entry pending-write scoreboard that gates instruction issue against write-after-write hazards. It sits between the execute/memory stages and the register file write port. Its registered outputs drive the register file's write enable, write address and write data directly. An optional bypass path exposes the in-flight write to the read stage.

## Interface
- NREQ, 3, number of writeback requesters (2..4)
- XLEN, 64, data width
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  NREQ  requester i has a write pending
- req_rd  in  5*NREQ  destination for requester i, bits [5i+4:5i]
- req_data  in  XLEN*NREQ  write data for requester i, bits [XLEN*i+XLEN-1:XLEN*i]
- req_ready  out  NREQ  one-hot grant; handshake completes when valid && ready
- rf_write  out  1  register file write enable
- rf_rd  out  5  register file write address
- rf_data  out  XLEN  register file write data
- issue_valid  in  1  decode wants to issue an instruction writing issue_rd
- issue_rd  in  5  destination of the issuing instruction
- issue_ready  out  1  issue is accepted this cycle
- busy  out  32  scoreboard; bit r set means a write to xr is outstanding
- byp_rs1_addr, byp_rs2_addr  in  5 each  read-stage source addresses
- byp_rs1_hit, byp_rs2_hit  out  1 each  the in-flight write matches the address
- byp_rs1_data, byp_rs2_data  out  XLEN each  bypassed data

## Operation
- **Arbitration**
  - Round-robin over req_valid. The search starts at last_grant+1 and wraps modulo NREQ.
  - last_grant updates only on a completed handshake.
  - At most one req_ready bit is high per cycle. req_ready is zero when no request is valid.
  - req_ready is combinational from req_valid and the pointer. A requester must hold rd and data stable while valid && !ready.
- **Output register**
  - On a handshake, rf_rd and rf_data capture the winner's fields on the next edge.
  - rf_write captures (winner rd != 0).
  - With no handshake, rf_write is 0 on the next edge and rf_rd/rf_data hold their values.
  - The output stage never stalls, so a grant is possible every cycle.
- **x0 writes**
  - The handshake completes and the pointer advances.
  - rf_write stays 0.
- **Scoreboard**
  - issue_ready = issue_rd == 0 || !busy[issue_rd].
  - When issue_valid && issue_ready && issue_rd != 0, busy[issue_rd] is set at the edge.
  - When a handshake completes for rd r, busy[r] is cleared at the same edge. Data reaches the file one cycle later via rf_write.
  - If set and clear hit the same register in the same cycle, set wins.
  - busy[0] is constant 0.
- **Bypass**
  - hit = rf_write && rf_rd == addr && addr != 0. data = rf_data when hit, else 0.
  - This covers the cycle in which the register file's combinational read still returns the old value.
- **Reset**
  - Asynchronous, taking effect mid-operation: rf_write=0, rf_rd=0, rf_data=0, busy=0, last_grant=NREQ-1 (requester 0 wins first).
  - Any in-flight grant is discarded.

## Timing
- Grant to register file write: the handshake occurs in cycle N, rf_write is high in cycle N+1, and the register file holds the new value from cycle N+2.
- Issue to busy: busy is visible the cycle after the issue handshake.
- Clear timing: busy clears in cycle N+1. A dependent read in N+1 must use the bypass; a read in N+2 or later reads the file directly.
- Throughput: one write per cycle.
- Fairness: with all requesters continuously valid, each requester is granted once every NREQ cycles. Worst-case wait is NREQ-1 cycles.

## Configuration
- REGFILE_WB_BYPASS_EN defined: the bypass comparators and muxes are built as described under Operation.
- REGFILE_WB_BYPASS_EN undefined:
  - byp_*_hit is tied 0 and byp_*_data is tied 0. The ports remain present.
  - Decode must stall one extra cycle after busy clears before reading a register.

## Test plan
- Reset, then req_valid=3'b111 with rd=5/6/7 held for 3 cycles: grants in order 0,1,2; rf_write high for three consecutive cycles with rf_rd=5,6,7.
- Only requester 2 valid, rd=9, data=0xDEAD_BEEF: req_ready=3'b100 in the same cycle; next cycle rf_write=1, rf_rd=9, rf_data=0xDEADBEEF.
- Requester 0 writes rd=0: handshake completes and rf_write stays 0. The next grant goes to requester 1 even if requester 0 is still valid.
- Issue x12, then a second issue to x12: busy[12]=1 and issue_ready=0. A handshake for rd=12 in the same cycle as a re-issue of x12 leaves busy[12]=1.
- With REGFILE_WB_BYPASS_EN defined, rf_write=1, rf_rd=4, byp_rs1_addr=4, byp_rs2_addr=0: byp_rs1_hit=1 with rf_data, byp_rs2_hit=0. With the macro undefined, both hits are 0.
- Assert rst asynchronously while rf_write=1 and busy=0x0000_1010: outputs clear immediately without a clock. After release, requester 0 wins the first grant.
